// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage. Steers byte lanes onto a req/gnt/rvalid
// data port, sign/zero-extends load data, bounds each access with a timeout and
// hands one registered result to writeback.
// Build option: define MISALIGN_TRAP_EN to fault misaligned half/word accesses;
// otherwise the offending low address bits are cleared and the access proceeds.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_rs2,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [4:0]  ex_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        lsu_fault,
  output logic [31:0] fault_addr
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t state, state_next;

  logic             accept;
  logic             is_mem;
  logic             illegal;
  logic             acc_fault;
  logic [31:0]      addr_eff;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic             timeout_hit;
  logic             timeout_c;
  logic [CNT_W-1:0] cnt;

  logic [31:0]      lat_addr;
  logic [1:0]       lat_off;
  logic [2:0]       lat_funct3;
  logic             lat_is_load;
  logic [4:0]       lat_rd;

  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      load_data;

  // Decode the incoming op: legality, alignment handling and byte-lane steering
  always_comb begin
    is_mem   = ex_is_load | ex_is_store;
    accept   = (state == S_IDLE) & ex_valid;
    illegal  = is_mem & ((ex_funct3[1:0] == 2'b11) | (ex_funct3[2:1] == 2'b11) |
                         (ex_is_load & ex_is_store));
    addr_eff = ex_alu_result;
`ifdef MISALIGN_TRAP_EN
    acc_fault = illegal |
                (is_mem & (((ex_funct3[1:0] == 2'b01) & ex_alu_result[0]) |
                           ((ex_funct3[1:0] == 2'b10) & (|ex_alu_result[1:0]))));
`else
    acc_fault = illegal;
    if (ex_funct3[1:0] == 2'b01) begin
      addr_eff[0] = 1'b0;
    end else if (ex_funct3[1:0] == 2'b10) begin
      addr_eff[1:0] = 2'b00;
    end
`endif
    case (ex_funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr_eff[1:0];
        wdata_c = {4{ex_rs2[7:0]}};
      end
      2'b01: begin
        be_c    = addr_eff[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{ex_rs2[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = ex_rs2;
      end
    endcase
  end

  // Select and extend the addressed byte/half of the returned load word
  always_comb begin
    byte_v = mem_rdata[{lat_off, 3'b000} +: 8];
    half_v = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_funct3)
      3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_data = {24'd0, byte_v};
      3'b001:  load_data = {{16{half_v[15]}}, half_v};
      3'b101:  load_data = {16'd0, half_v};
      default: load_data = mem_rdata;
    endcase
  end

  // Next-state logic; a grant or response in the final budget cycle wins over timeout
  always_comb begin
    state_next  = state;
    timeout_c   = 1'b0;
    timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = (is_mem && !acc_fault) ? S_REQ : S_WB;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_next = lat_is_load ? S_RESP : S_WB;
        end else if (timeout_hit) begin
          state_next = S_WB;
          timeout_c  = 1'b1;
        end
      end
      S_RESP: begin
        if (mem_rvalid) begin
          state_next = S_WB;
        end else if (timeout_hit) begin
          state_next = S_WB;
          timeout_c  = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered bus, writeback and bookkeeping outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ready    <= 1'b1;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      mem_be      <= 4'd0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= 32'd0;
      lsu_fault   <= 1'b0;
      fault_addr  <= 32'd0;
      cnt         <= '0;
      lat_addr    <= 32'd0;
      lat_off     <= 2'd0;
      lat_funct3  <= 3'd0;
      lat_is_load <= 1'b0;
      lat_rd      <= 5'd0;
    end else begin
      ex_ready  <= (state_next == S_IDLE);
      mem_req   <= (state_next == S_REQ);
      wb_valid  <= (state_next == S_WB);
      wb_we     <= 1'b0;
      lsu_fault <= 1'b0;

      if (state == S_REQ || state == S_RESP) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (accept) begin
        cnt         <= '0;
        lat_addr    <= ex_alu_result;
        lat_off     <= addr_eff[1:0];
        lat_funct3  <= ex_funct3;
        lat_is_load <= ex_is_load;
        lat_rd      <= ex_rd;
        wb_rd       <= ex_rd;
        if (!is_mem) begin
          wb_data <= ex_alu_result;
          wb_we   <= (ex_rd != 5'd0);
        end else if (acc_fault) begin
          wb_data    <= 32'd0;
          lsu_fault  <= 1'b1;
          fault_addr <= ex_alu_result;
        end else begin
          wb_data   <= 32'd0;
          mem_we    <= ex_is_store;
          mem_addr  <= {addr_eff[31:2], 2'b00};
          mem_be    <= be_c;
          mem_wdata <= wdata_c;
        end
      end

      if (timeout_c) begin
        lsu_fault  <= 1'b1;
        fault_addr <= lat_addr;
        wb_data    <= 32'd0;
      end

      if (state == S_RESP && mem_rvalid) begin
        wb_data <= load_data;
        wb_we   <= (lat_rd != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven directed vectors plus hand-written sequences
// for stale rvalid, delayed grant, timeout and mid-transaction reset.
module tb_load_store_unit;

  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_BOTH  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_rs2;
  logic [2:0]  ex_funct3;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [4:0]  ex_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lsu_fault;
  logic [31:0] fault_addr;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_result(ex_alu_result),
    .ex_rs2(ex_rs2), .ex_funct3(ex_funct3), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .lsu_fault(lsu_fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [4:0]  rd;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    logic        e_fault;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_wb_we;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int kind, logic [2:0] f3, logic [31:0] addr, logic [31:0] rs2,
                              logic [4:0] rd, int gd, int rvd, logic [31:0] rdata,
                              logic ef, logic [31:0] ea, logic [3:0] ebe, logic [31:0] ew,
                              logic ewe, logic [31:0] ed);
    vec_t v;
    v.kind = kind; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.rd = rd;
    v.gnt_dly = gd; v.rv_dly = rvd; v.rdata = rdata; v.e_fault = ef;
    v.e_addr = ea; v.e_be = ebe; v.e_wdata = ew; v.e_wb_we = ewe; v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string tag, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", tag, field, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [4:0] rd, input string tag);
    for (int i = 0; i < 10 && !ex_ready; i++) tick();
    chk(tag, "ready_before", 32'(ex_ready), 32'd1);
    ex_valid      = 1'b1;
    ex_alu_result = addr;
    ex_rs2        = rs2;
    ex_funct3     = f3;
    ex_is_load    = (kind == K_LOAD) || (kind == K_BOTH);
    ex_is_store   = (kind == K_STORE) || (kind == K_BOTH);
    ex_rd         = rd;
    tick();
    ex_valid    = 1'b0;
    ex_is_load  = 1'b0;
    ex_is_store = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    issue(v.kind, v.f3, v.addr, v.rs2, v.rd, tag);
    chk(tag, "ready_busy", 32'(ex_ready), 32'd0);
    if (!v.e_fault && (v.kind == K_LOAD || v.kind == K_STORE)) begin
      for (int k = 0; k <= v.gnt_dly; k++) begin
        chk(tag, "req", 32'(mem_req), 32'd1);
        chk(tag, "addr", mem_addr, v.e_addr);
        chk(tag, "be", 32'(mem_be), 32'(v.e_be));
        chk(tag, "we", 32'(mem_we), 32'(v.kind == K_STORE));
        if (v.kind == K_STORE) chk(tag, "wdata", mem_wdata, v.e_wdata);
        if (k == v.gnt_dly) mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
      end
      if (v.kind == K_LOAD) begin
        for (int j = 0; j <= v.rv_dly; j++) begin
          chk(tag, "req_resp", 32'(mem_req), 32'd0);
          chk(tag, "wbv_resp", 32'(wb_valid), 32'd0);
          if (j == v.rv_dly) begin
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
          end
          tick();
          mem_rvalid = 1'b0;
          mem_rdata  = 32'h5A5A_5A5A;
        end
      end
    end
    chk(tag, "wb_valid", 32'(wb_valid), 32'd1);
    chk(tag, "wb_we", 32'(wb_we), 32'(v.e_wb_we));
    chk(tag, "wb_rd", 32'(wb_rd), 32'(v.rd));
    chk(tag, "fault", 32'(lsu_fault), 32'(v.e_fault));
    chk(tag, "req_wb", 32'(mem_req), 32'd0);
    if (v.e_fault) chk(tag, "fault_addr", fault_addr, v.addr);
    else if (v.kind == K_LOAD || v.kind == K_ALU) chk(tag, "wb_data", wb_data, v.e_data);
    tick();
    chk(tag, "wb_valid_end", 32'(wb_valid), 32'd0);
    chk(tag, "fault_end", 32'(lsu_fault), 32'd0);
    chk(tag, "ready_end", 32'(ex_ready), 32'd1);
  endtask

  initial begin
    int n;
    // kind, f3, addr, rs2, rd, gnt_dly, rv_dly, rdata, fault, mem_addr, be, wdata, wb_we, wb_data
    vecs.push_back(mk(K_STORE, 3'b000, 32'h1003, 32'h0000_00A5, 5'd0, 0, 0, 32'h0, 1'b0, 32'h1000, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'h0));
    vecs.push_back(mk(K_LOAD,  3'b000, 32'h2001, 32'h0, 5'd3, 0, 0, 32'h0000_F700, 1'b0, 32'h2000, 4'b0010, 32'h0, 1'b1, 32'hFFFF_FFF7));
    vecs.push_back(mk(K_LOAD,  3'b100, 32'h2001, 32'h0, 5'd3, 0, 1, 32'h0000_F700, 1'b0, 32'h2000, 4'b0010, 32'h0, 1'b1, 32'h0000_00F7));
    vecs.push_back(mk(K_LOAD,  3'b001, 32'h2002, 32'h0, 5'd4, 3, 1, 32'h8001_0000, 1'b0, 32'h2000, 4'b1100, 32'h0, 1'b1, 32'hFFFF_8001));
    vecs.push_back(mk(K_LOAD,  3'b101, 32'h2002, 32'h0, 5'd7, 1, 0, 32'h8001_0000, 1'b0, 32'h2000, 4'b1100, 32'h0, 1'b1, 32'h0000_8001));
    vecs.push_back(mk(K_STORE, 3'b001, 32'h4002, 32'h1234_ABCD, 5'd2, 2, 0, 32'h0, 1'b0, 32'h4000, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0));
    vecs.push_back(mk(K_STORE, 3'b001, 32'h4000, 32'h1234_ABCD, 5'd2, 0, 0, 32'h0, 1'b0, 32'h4000, 4'b0011, 32'hABCD_ABCD, 1'b0, 32'h0));
    vecs.push_back(mk(K_STORE, 3'b010, 32'h5000, 32'hDEAD_BEEF, 5'd1, 0, 0, 32'h0, 1'b0, 32'h5000, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0));
    vecs.push_back(mk(K_LOAD,  3'b010, 32'h6004, 32'h0, 5'd31, 0, 2, 32'h89AB_CDEF, 1'b0, 32'h6004, 4'b1111, 32'h0, 1'b1, 32'h89AB_CDEF));
    vecs.push_back(mk(K_LOAD,  3'b000, 32'h0010, 32'h0, 5'd0, 0, 0, 32'h0000_0080, 1'b0, 32'h0010, 4'b0001, 32'h0, 1'b0, 32'hFFFF_FF80));
    vecs.push_back(mk(K_ALU,   3'b000, 32'h1234, 32'h0, 5'd0, 0, 0, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0, 1'b0, 32'h0000_1234));
    vecs.push_back(mk(K_ALU,   3'b111, 32'h1234, 32'h0, 5'd5, 0, 0, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0, 1'b1, 32'h0000_1234));
    vecs.push_back(mk(K_LOAD,  3'b011, 32'h7000, 32'h0, 5'd8, 0, 0, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 1'b0, 32'h0));
    vecs.push_back(mk(K_STORE, 3'b110, 32'h7008, 32'h0, 5'd8, 0, 0, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 1'b0, 32'h0));
    vecs.push_back(mk(K_BOTH,  3'b010, 32'h7104, 32'h0, 5'd8, 0, 0, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 1'b0, 32'h0));
`ifdef MISALIGN_TRAP_EN
    vecs.push_back(mk(K_LOAD,  3'b010, 32'h3002, 32'h0, 5'd6, 0, 0, 32'h1122_3344, 1'b1, 32'h0, 4'b0, 32'h0, 1'b0, 32'h0));
    vecs.push_back(mk(K_LOAD,  3'b001, 32'h2003, 32'h0, 5'd6, 0, 0, 32'hAABB_CCDD, 1'b1, 32'h0, 4'b0, 32'h0, 1'b0, 32'h0));
    vecs.push_back(mk(K_STORE, 3'b001, 32'h4001, 32'h0000_BEEF, 5'd6, 0, 0, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0, 1'b0, 32'h0));
`else
    vecs.push_back(mk(K_LOAD,  3'b010, 32'h3002, 32'h0, 5'd6, 0, 0, 32'h1122_3344, 1'b0, 32'h3000, 4'b1111, 32'h0, 1'b1, 32'h1122_3344));
    vecs.push_back(mk(K_LOAD,  3'b001, 32'h2003, 32'h0, 5'd6, 0, 0, 32'hAABB_CCDD, 1'b0, 32'h2000, 4'b1100, 32'h0, 1'b1, 32'hFFFF_AABB));
    vecs.push_back(mk(K_STORE, 3'b001, 32'h4001, 32'h0000_BEEF, 5'd6, 0, 0, 32'h0, 1'b0, 32'h4000, 4'b0011, 32'hBEEF_BEEF, 1'b0, 32'h0));
`endif

    rst_n = 1'b0; ex_valid = 1'b0; ex_alu_result = '0; ex_rs2 = '0; ex_funct3 = '0;
    ex_is_load = 1'b0; ex_is_store = 1'b0; ex_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    tick();

    // Reset state
    chk("reset", "ex_ready", 32'(ex_ready), 32'd1);
    chk("reset", "mem_req", 32'(mem_req), 32'd0);
    chk("reset", "mem_we", 32'(mem_we), 32'd0);
    chk("reset", "mem_be", 32'(mem_be), 32'd0);
    chk("reset", "mem_addr", mem_addr, 32'd0);
    chk("reset", "wb_valid", 32'(wb_valid), 32'd0);
    chk("reset", "wb_data", wb_data, 32'd0);
    chk("reset", "lsu_fault", 32'(lsu_fault), 32'd0);

    // Stale rvalid after reset release must not retire anything
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stale", "wb_valid", 32'(wb_valid), 32'd0);
      chk("stale", "ex_ready", 32'(ex_ready), 32'd1);
    end
    mem_rvalid = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // rvalid while still waiting for grant is ignored
    issue(K_LOAD, 3'b010, 32'h8008, 32'h0, 5'd9, "rv_req");
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BAD_0BAD;
    for (int i = 0; i < 2; i++) begin
      chk("rv_req", "req", 32'(mem_req), 32'd1);
      tick();
      chk("rv_req", "wb_valid", 32'(wb_valid), 32'd0);
    end
    mem_rvalid = 1'b0;
    mem_gnt    = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    chk("rv_req", "wb_valid", 32'(wb_valid), 32'd1);
    chk("rv_req", "wb_data", wb_data, 32'hCAFE_F00D);
    chk("rv_req", "wb_we", 32'(wb_we), 32'd1);
    tick();

    // Timeout: grant never arrives, mem_req held for exactly 8 cycles
    issue(K_LOAD, 3'b010, 32'h9000, 32'h0, 5'd4, "timeout");
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      chk("timeout", "ex_ready_busy", 32'(ex_ready), 32'd0);
      tick();
    end
    chk("timeout", "req_cycles", 32'(n), 32'd8);
    chk("timeout", "lsu_fault", 32'(lsu_fault), 32'd1);
    chk("timeout", "wb_valid", 32'(wb_valid), 32'd1);
    chk("timeout", "wb_we", 32'(wb_we), 32'd0);
    chk("timeout", "fault_addr", fault_addr, 32'h9000);
    tick();
    chk("timeout", "ex_ready", 32'(ex_ready), 32'd1);
    chk("timeout", "fault_end", 32'(lsu_fault), 32'd0);

    // Async reset mid-transaction aborts without retiring
    issue(K_LOAD, 3'b010, 32'hA000, 32'h0, 5'd10, "abort");
    chk("abort", "req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort", "req_async", 32'(mem_req), 32'd0);
    chk("abort", "ready_async", 32'(ex_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort", "wb_valid", 32'(wb_valid), 32'd0);
      chk("abort", "req", 32'(mem_req), 32'd0);
    end
    mem_rvalid = 1'b0;

    // Unit still works after the abort
    run_vec(mk(K_ALU, 3'b000, 32'h0000_BEEF, 32'h0, 5'd12, 0, 0, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0, 1'b1, 32'h0000_BEEF), 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
